// File: rtl/tt_um_alexlowl_myttproject.sv
// Running-light user tile: a one-hot LED pattern on uo_out rotates at one of eight
// prescaled rates, with pause/faster/slower push buttons on ui_in[2:0].
module tt_um_alexlowl_myttproject #(
  parameter int unsigned DIV_EXP = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [2:0]         sync1_q, sync2_q, prev_q;
  logic [2:0]         btn_ev;
  logic               running_q, running_d;
  logic [2:0]         level_q, level_d;
  logic [7:0]         pattern_q, pattern_d;
  logic [DIV_EXP-1:0] cnt_q, cnt_d;
  logic [DIV_EXP-1:0] cnt_last;
  logic               unused_inputs;

  assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:3]};

  // Two-flop synchronizer followed by a previous-value flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      prev_q  <= 3'b000;
    end else begin
      sync1_q <= ui_in[2:0];
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign btn_ev = sync2_q & ~prev_q;

  // Terminal count P-1 = 2^(DIV_EXP-level) - 1, i.e. DIV_EXP-level low ones.
  assign cnt_last = {DIV_EXP{1'b1}} >> level_q;

  always_comb begin
    running_d = running_q ^ btn_ev[0];
    level_d   = level_q;
    pattern_d = pattern_q;
    cnt_d     = cnt_q;

    if (btn_ev[1] && !btn_ev[2] && (level_q != 3'd7)) begin
      level_d = level_q + 3'd1;
    end else if (btn_ev[2] && !btn_ev[1] && (level_q != 3'd0)) begin
      level_d = level_q - 3'd1;
    end

    // A speed change restarts the step interval and takes priority over a pending step.
    if (level_d != level_q) begin
      cnt_d = '0;
    end else if (running_q) begin
      if (cnt_q == cnt_last) begin
        cnt_d     = '0;
        pattern_d = {pattern_q[6:0], pattern_q[7]};
      end else begin
        cnt_d = cnt_q + {{(DIV_EXP-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q <= 1'b0;
      level_q   <= 3'd3;
      pattern_q <= 8'b0000_0001;
      cnt_q     <= '0;
    end else begin
      running_q <= running_d;
      level_q   <= level_d;
      pattern_q <= pattern_d;
      cnt_q     <= cnt_d;
    end
  end

  assign uo_out  = pattern_q;
  assign uio_out = {4'b0000, running_q, level_q};
  assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_alexlowl_myttproject.sv
// Directed bench for the running-light tile with DIV_EXP = 8 (level 3 -> 32-cycle steps).
module tb_tt_um_alexlowl_myttproject;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [2:0] btn;
  logic [4:0] junk;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_total = 0;
  int n_pass  = 0;

  assign ui_in = {junk, btn};

  tt_um_alexlowl_myttproject #(
    .DIV_EXP(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges, landing 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Button press whose event lands on the third edge, then a release long enough to re-arm.
  task automatic pulse(input int idx);
    btn[idx] = 1'b1;
    step(3);
    btn = 3'b000;
    step(3);
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    btn    = 3'b000;
    junk   = 5'h15;
    uio_in = 8'hA5;

    // Reset
    step(15);
    check("rst_uo", uo_out, 8'h01);
    check("rst_uio", uio_out, 8'h03);
    check("rst_oe", uio_oe, 8'h0F);
    rst_n = 1'b1;
    step(50);
    check("idle_uo", uo_out, 8'h01);
    check("idle_uio", uio_out, 8'h03);

    // Start running: running rises on edge E, first step at E+32
    btn[0] = 1'b1;
    step(2);
    check("run_lat2", uio_out, 8'h03);
    step(1);
    check("run_lat3", uio_out, 8'h0B);
    step(12);
    btn = 3'b000;
    step(19);
    check("step1_pre", uo_out, 8'h01);
    step(1);
    check("step1", uo_out, 8'h02);
    step(32);
    check("step2", uo_out, 8'h04);
    step(160);
    check("step7", uo_out, 8'h80);
    step(32);
    check("wrap", uo_out, 8'h01);

    // Faster: level 4, counter cleared, 16-cycle steps
    btn[1] = 1'b1;
    step(3);
    btn = 3'b000;
    check("faster_lvl", uio_out, 8'h0C);
    step(15);
    check("l4_pre", uo_out, 8'h01);
    step(1);
    check("l4_step1", uo_out, 8'h02);
    step(16);
    check("l4_step2", uo_out, 8'h04);

    // Slower: back to level 3, 32-cycle steps from the cleared counter
    btn[2] = 1'b1;
    step(3);
    btn = 3'b000;
    check("slower_lvl", uio_out, 8'h0B);
    step(31);
    check("l3_pre", uo_out, 8'h04);
    step(1);
    check("l3_step", uo_out, 8'h08);

    // Pause: counter holds at 3, pattern frozen
    btn[0] = 1'b1;
    step(3);
    btn = 3'b000;
    check("pause_flag", uio_out, 8'h03);
    step(1000);
    check("pause_frozen", uo_out, 8'h08);
    btn[0] = 1'b1;
    step(3);
    btn = 3'b000;
    check("resume_flag", uio_out, 8'h0B);
    step(28);
    check("resume_pre", uo_out, 8'h08);
    step(1);
    check("resume_step", uo_out, 8'h10);

    // Pause, then saturate upward while paused
    btn[0] = 1'b1;
    step(3);
    btn = 3'b000;
    step(3);
    for (int i = 0; i < 6; i++) pulse(1);
    check("sat_hi_lvl", uio_out, 8'h07);
    check("sat_hi_hold", uo_out, 8'h10);

    // Level 7: period 2
    btn[0] = 1'b1;
    step(3);
    btn = 3'b000;
    check("l7_run", uio_out, 8'h0F);
    step(1);
    check("l7_c1", uo_out, 8'h10);
    step(1);
    check("l7_c2", uo_out, 8'h20);
    step(2);
    check("l7_c4", uo_out, 8'h40);
    btn[0] = 1'b1;
    step(3);
    btn = 3'b000;
    check("l7_pause_flag", uio_out, 8'h07);
    check("l7_pause_pat", uo_out, 8'h80);
    step(3);

    // Saturate downward: level 0, period 256
    for (int i = 0; i < 9; i++) pulse(2);
    check("sat_lo_lvl", uio_out, 8'h00);
    btn[0] = 1'b1;
    step(3);
    btn = 3'b000;
    check("l0_run", uio_out, 8'h08);
    step(255);
    check("l0_pre", uo_out, 8'h80);
    step(1);
    check("l0_step", uo_out, 8'h01);

    // Pause, return to level 3, then simultaneous faster+slower
    btn[0] = 1'b1;
    step(3);
    btn = 3'b000;
    step(3);
    for (int i = 0; i < 3; i++) pulse(1);
    check("back_l3", uio_out, 8'h03);
    btn = 3'b110;
    step(3);
    btn = 3'b000;
    check("both_speed", uio_out, 8'h03);
    step(3);

    // Held pause button: one toggle only; rotations at A+32k from a cleared counter
    btn[0] = 1'b1;
    step(500);
    check("held_once", uio_out, 8'h0B);
    btn = 3'b000;
    step(3);
    check("held_release", uio_out, 8'h0B);
    check("held_pattern", uo_out, 8'h80);

    // Asynchronous reset mid-run, observed before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_uo", uo_out, 8'h01);
    check("async_uio", uio_out, 8'h03);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tt_um_alexlowl_myttproject.md
Name: tt_um_alexlowl_myTTproject

Overview:
- Tiny Tapeout user module that drives a rotating single-LED "running light" on uo_out.
- Three push-button inputs control it:
  - pause/run toggle
  - faster
  - slower
- Speed is an 8-level prescaler off the 50 MHz system clock.
- Current state is mirrored on uio_out for debug.

Parameters:
- DIV_EXP, default 24: base exponent; step period is 2^(DIV_EXP - level) clock cycles. Must be ≥ 8. Use 24 in silicon; benches may shrink it (e.g. 8).

Ports:
- clk     in   1  system clock, 50 MHz nominal
- rst_n   in   1  asynchronous active-low reset
- ena     in   1  tile enable; ignored by logic
- ui_in   in   8  [0] pause/run button, [1] faster button, [2] slower button; [7:3] unused
- uo_out  out  8  running-light pattern, one-hot
- uio_in  in   8  unused
- uio_out out  8  [2:0] speed level, [3] running flag, [7:4] = 0
- uio_oe  out  8  constant 8'h0F

Behaviour:
- Reset (rst_n low, asynchronous):
  - pattern = 8'b0000_0001
  - running = 0 (paused)
  - level = 3
  - prescaler counter = 0
  - synchronizer/edge flops = 0
  - uio_out = 8'h03
- Reset release is used synchronously; no action occurs on the releasing edge.
- Button inputs ui_in[2:0]: each passes through a 2-flop synchronizer, then a previous-value flop.
  - An event is a rising edge: sync2 = 1 and prev = 0, lasting exactly one cycle.
  - Input held high yields one event only. Release yields nothing.
  - No debounce counter.
  - Latency: if an input rises before posedge N, its event is visible in state after posedge N+2.
- Pause event: running toggles (0→1 or 1→0).
- Faster event: level increments, saturating at 7.
- Slower event: level decrements, saturating at 0.
- Faster and slower events in the same cycle: level unchanged.
- Pause and a speed event in the same cycle: both take effect.
- Any effective level change clears the prescaler counter to 0 on the same edge.
- Prescaler (width DIV_EXP bits):
  - period P = 1 << (DIV_EXP - level).
  - While running = 1, counter increments every cycle.
  - When counter == P-1, the counter returns to 0 and the pattern rotates left by one (bit7 wraps to bit0).
  - While running = 0, counter and pattern hold their values (pause does not clear the counter).
- First step after run begins: P cycles after running goes high, assuming a fresh counter.
- Pattern is always exactly one-hot. Eight steps return it to its start value.
- Outputs are registered; uo_out = pattern directly.
- uio_out = {4'b0, running, level}.
- ena, uio_in and ui_in[7:3] have no effect.
- Silicon timing with DIV_EXP = 24 at 50 MHz:
  - level 3: P = 2^21 cycles ≈ 41.9 ms per step
  - level 7: ≈ 2.6 ms per step
  - level 0: ≈ 335 ms per step

Test Plan:
- Reset: hold rst_n low for 15 cycles with ui_in = 0 → uo_out = 8'h01, uio_out = 8'h03, uio_oe = 8'h0F. After release with no buttons, uo_out stays 8'h01 indefinitely.
- Run (DIV_EXP = 8): pulse ui_in[0] high for 15 cycles, then low → running = 1 after 3 edges.
  - uo_out becomes 8'h02 32 cycles later, then 8'h04 after 32 more.
  - Wraps from 8'h80 to 8'h01.
- Speed: while running, pulse ui_in[1] → level 4, step every 16 cycles. Then pulse ui_in[2] → level 3, step every 32 cycles. Counter clears at each change.
- Saturation: pulse faster 6 times → level 7 (uio_out[2:0] = 7, period 2). Pulse slower 9 times → level 0, period 256, no wrap of level.
- Pause: while running, pulse ui_in[0] → uio_out[3] = 0 and uo_out frozen for 1000 cycles. A second pulse resumes, and the remaining step time continues from the held count.
- Corners:
  - ui_in[1] and ui_in[2] rising on the same cycle → level unchanged.
  - ui_in[0] held high for 500 cycles → exactly one toggle.
  - rst_n asserted mid-run → outputs return to reset values immediately, without waiting for a clock edge.
